// File: rtl/regfile_wb_pkg.sv
// Shared types and default sizing for the register-file write-back arbiter.
package regfile_wb_pkg;

    localparam int WB_WIDTH = 32;
    localparam int WB_N     = 5;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic                en;
        logic [WB_N-1:0]     index;
        logic [WB_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// Circular buffer of write-back entries. The caller only asserts enq_i when
// the buffer is not full or a dequeue happens in the same cycle. A full
// buffer may be written while its head is read, because the head leaves at
// the same edge.
module regfile_wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int  DEPTH   = WB_DEPTH,
    parameter type entry_t = wb_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enq_i,
    input  entry_t                   enq_data_i,
    input  logic                     deq_i,
    output entry_t                   head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq_i) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({enq_i, deq_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset drops every queued entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; stale contents are never marked valid.
    always_ff @(posedge clk_i) begin
        if (enq_i) mem_q[wr_ptr_q] <= enq_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Write-back arbiter: merges ALU (A) and memory (B) write requests into one
// FIFO stream toward the register file, round-robin under contention.
// Optional build macro REGFILE_WB_ZERO_GUARD_EN: requests targeting index 0
// are queued with EN cleared so register 0 is never written.
module regfile_writeback_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int N     = WB_N,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   a_en_i,
    input  logic [N-1:0]           a_index_i,
    input  logic [WIDTH-1:0]       a_data_i,
    input  logic                   a_valid_i,
    output logic                   a_consumed_o,
    input  logic                   b_en_i,
    input  logic [N-1:0]           b_index_i,
    input  logic [WIDTH-1:0]       b_data_i,
    input  logic                   b_valid_i,
    output logic                   b_consumed_o,
    output logic                   write_en_write_o,
    output logic [N-1:0]           write_index_write_o,
    output logic [WIDTH-1:0]       write_data_write_o,
    output logic                   write_en_write_valid_o,
    output logic                   write_index_write_valid_o,
    output logic                   write_data_write_valid_o,
    input  logic                   write_en_write_consumed_i,
    input  logic                   write_index_write_consumed_i,
    input  logic                   write_data_write_consumed_i,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    typedef struct packed {
        logic             en;
        logic [N-1:0]     index;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t enq_entry, head;
    logic   full, empty, deq, can_enq, enq;
    src_e   grant, rr_q, rr_d;

    // Arbitration and handshakes; the register file's consumed feeds straight
    // through to the producers so a full queue can refill as it drains.
    always_comb begin
        deq     = !empty && write_en_write_consumed_i
                         && write_index_write_consumed_i
                         && write_data_write_consumed_i;
        can_enq = !full || deq;

        if (a_valid_i && !b_valid_i)      grant = SRC_A;
        else if (b_valid_i && !a_valid_i) grant = SRC_B;
        else                              grant = rr_q;

        enq = (a_valid_i || b_valid_i) && can_enq;

        rr_d = rr_q;
        if (a_valid_i && b_valid_i && can_enq) rr_d = other_src(grant);

        a_consumed_o = !a_valid_i || ((grant == SRC_A) && can_enq);
        b_consumed_o = !b_valid_i || ((grant == SRC_B) && can_enq);

        if (grant == SRC_A) enq_entry = '{en: a_en_i, index: a_index_i, data: a_data_i};
        else                enq_entry = '{en: b_en_i, index: b_index_i, data: b_data_i};
`ifdef REGFILE_WB_ZERO_GUARD_EN
        if (enq_entry.index == '0) enq_entry.en = 1'b0;
`endif
    end

    // Round-robin favourite; A wins the first contention after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) rr_q <= SRC_A;
        else       rr_q <= rr_d;
    end

    regfile_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enq_i      (enq),
        .enq_data_i (enq_entry),
        .deq_i      (deq),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (occupancy_o)
    );

    assign write_en_write_o          = head.en;
    assign write_index_write_o       = head.index;
    assign write_data_write_o        = head.data;
    assign write_en_write_valid_o    = !empty;
    assign write_index_write_valid_o = !empty;
    assign write_data_write_valid_o  = !empty;

endmodule
